// File: rtl/sim_status_port.sv
// Memory-mapped test terminator: decodes CPU stores into pass/fail/timeout state and logs progress values.
// Flags update on the edge that samples the deciding store; log FIFO drops pushes when full with no pop and sets a sticky overflow.
module sim_status_port #(
  parameter logic [15:0] LOG_ADDR       = 16'd80,
  parameter logic [15:0] RESULT_ADDR    = 16'd84,
  parameter logic [15:0] STATUS_ADDR    = 16'd88,
  parameter logic [15:0] PASS_CODE      = 16'd7,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [15:0] addr,
  input  logic [15:0] wd,
  output logic [15:0] rd,
  output logic        sel,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [15:0] err_addr,
  output logic [15:0] err_data,
  output logic [15:0] write_count,
  output logic        log_valid,
  output logic [15:0] log_data,
  input  logic        log_pop,
  output logic        log_overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [15:0]   err_addr_q, err_addr_d;
  logic [15:0]   err_data_q, err_data_d;
  logic [15:0]   wc_q, wc_d;
  logic          done_q, pass_q, fail_q, timeout_q;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [15:0]   mem_q [LOG_DEPTH];

  logic log_hit, res_hit, stat_hit;
  logic push, pop, full, push_ok, term;

  assign log_hit  = (addr == LOG_ADDR);
  assign res_hit  = (addr == RESULT_ADDR);
  assign stat_hit = (addr == STATUS_ADDR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    wc_d       = wc_q;
    push       = 1'b0;
    term       = 1'b0;
    if (state_q == ST_RUN) begin
      cnt_d = cnt_q + 32'd1;
      if (memwrite && res_hit) begin
        term = 1'b1;
        if (wd == PASS_CODE) begin
          state_d = ST_PASS;
        end else begin
          state_d    = ST_FAIL;
          err_addr_d = addr;
          err_data_d = wd;
        end
      end else if (memwrite && log_hit) begin
        push = 1'b1;
        if (wc_q != 16'hFFFF) wc_d = wc_q + 16'd1;
      end else if (memwrite) begin
        // Any store outside the log/result words is a stray access.
        term       = 1'b1;
        state_d    = ST_FAIL;
        err_addr_d = addr;
        err_data_d = wd;
      end
      if (!term && cnt_q == TIMEOUT_CYCLES - 32'd1) state_d = ST_TIMEOUT;
    end
  end

  always_comb begin
    pop      = log_pop && (fcnt_q != '0);
    full     = (fcnt_q == CW'(LOG_DEPTH));
    push_ok  = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      wc_q       <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      wc_q       <= wc_d;
      done_q     <= (state_d != ST_RUN);
      pass_q     <= (state_d == ST_PASS);
      fail_q     <= (state_d == ST_FAIL);
      timeout_q  <= (state_d == ST_TIMEOUT);
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= wd;
  end

  always_comb begin
    rd = 16'h0000;
    if (stat_hit)     rd = {11'b0, ovf_q, timeout_q, fail_q, pass_q, done_q};
    else if (log_hit) rd = wc_q;
  end

  assign sel          = log_hit || res_hit || stat_hit;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign err_addr     = err_addr_q;
  assign err_data     = err_data_q;
  assign write_count  = wc_q;
  assign log_valid    = (fcnt_q != '0);
  assign log_data     = mem_q[rd_ptr_q];
  assign log_overflow = ovf_q;

endmodule
